// File: rtl/bus_rx_pkg.sv
// Shared types and constants for the tri-state bus receiver slice.
package bus_rx_pkg;

   // Receive FSM: waiting for a window, debouncing it, or holding after capture
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } rx_state_e;

   // Width of the saturating aborted-window counter
   localparam int GLITCH_W = 8;

   // Debounce counter width; enough for a stable run of up to 15 samples
   localparam int CNT_W = 4;

   // FIFO pointers carry one extra wrap bit beyond the address bits,
   // so full and empty can be told apart when the addresses match
   function automatic int ptrWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// First-word-fall-through word FIFO for captured bus words. A push into a
// full FIFO is dropped unless a pop happens on the same edge, and any drop
// raises a sticky flag that only reset clears.
module rx_word_fifo
   import bus_rx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_dropFlag
);

   localparam int PTR_W  = ptrWidth(DEPTH);
   localparam int ADDR_W = PTR_W - 1;
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic              r_dropFlag;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_write;
   logic              w_drop;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [ADDR_W-1:0] w_rdAddr;

   assign w_wrAddr = r_wrPtr[ADDR_W-1:0];
   assign w_rdAddr = r_rdPtr[ADDR_W-1:0];
   assign w_empty  = (r_wrPtr == r_rdPtr);
   assign w_full   = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) && (w_wrAddr == w_rdAddr);

   // A pop on the same edge frees the head slot, so a push into a full
   // FIFO is still accepted when the consumer is draining at that moment
   assign w_pop    = !w_empty && i_ready;
   assign w_write  = i_push && (!w_full || w_pop);
   assign w_drop   = i_push && w_full && !w_pop;

   // Pointer and sticky drop-flag state; reset empties the FIFO outright
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_dropFlag <= 1'b0;
      end else begin
         if (w_write) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         if (w_drop) begin
            r_dropFlag <= 1'b1;
         end
      end
   end

   // Word storage needs no reset: the empty flag masks stale contents
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[w_wrAddr] <= i_data;
      end
   end

   assign o_valid    = !w_empty;
   assign o_data     = w_empty ? '0 : r_mem[w_rdAddr];
   assign o_dropFlag = r_dropFlag;

endmodule

// File: rtl/tristate_bus_receiver.sv
// Reader end of the shared tri-state bus. Samples the bus every cycle,
// keeps the last driven word, debounces each drive window and captures
// one stable word per window into a small valid/ready FIFO.
module tristate_bus_receiver
   import bus_rx_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 2,
   parameter int DEPTH         = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bus_drive_n,
   input  logic [WIDTH-1:0]    bus_data,
   output logic [WIDTH-1:0]    keep_data,
   output logic                floating,
   output logic                out_valid,
   output logic [WIDTH-1:0]    out_data,
   input  logic                out_ready,
   output logic                overflow,
   output logic [GLITCH_W-1:0] glitch_count
);

   localparam logic [CNT_W-1:0]    STABLE_CNT = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [GLITCH_W-1:0] GLITCH_ONE = {{(GLITCH_W-1){1'b0}}, 1'b1};

   logic                r_drive_n;
   logic [WIDTH-1:0]    r_data;
   logic [WIDTH-1:0]    r_keep;
   rx_state_e           r_state;
   rx_state_e           w_nextState;
   logic [WIDTH-1:0]    r_prev;
   logic [WIDTH-1:0]    w_nextPrev;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_nextCnt;
   logic                w_push;
   logic                w_glitch;
   logic [GLITCH_W-1:0] r_glitchCount;

   // Register the raw bus once; everything downstream sees only these copies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drive_n <= 1'b1;
         r_data    <= '0;
      end else begin
         r_drive_n <= bus_drive_n;
         r_data    <= bus_data;
      end
   end

   // Bus keeper: remember the last sample taken while somebody was driving
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_keep <= '0;
      end else if (!r_drive_n) begin
         r_keep <= r_data;
      end
   end

   // FSM state, candidate word and run length of identical samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_prev  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         r_prev  <= w_nextPrev;
         r_cnt   <= w_nextCnt;
      end
   end

   // Window debounce: a data change restarts the run, a release before the
   // run is long enough is an aborted window, and HOLD blocks a second capture
   always_comb begin
      w_nextState = r_state;
      w_nextPrev  = r_prev;
      w_nextCnt   = r_cnt;
      w_push      = 1'b0;
      w_glitch    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!r_drive_n) begin
               w_nextPrev = r_data;
               w_nextCnt  = CNT_ONE;
               if (STABLE_CNT == CNT_ONE) begin
                  w_push      = 1'b1;
                  w_nextState = HOLD;
               end else begin
                  w_nextState = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (r_drive_n) begin
               w_glitch    = 1'b1;
               w_nextState = IDLE;
            end else if (r_data != r_prev) begin
               w_nextPrev = r_data;
               w_nextCnt  = CNT_ONE;
            end else begin
               w_nextCnt = r_cnt + CNT_ONE;
               if ((r_cnt + CNT_ONE) == STABLE_CNT) begin
                  w_push      = 1'b1;
                  w_nextState = HOLD;
               end
            end
         end
         HOLD: begin
            if (r_drive_n) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Count aborted windows, sticking at the top value instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_glitchCount <= '0;
      end else if (w_glitch && (r_glitchCount != {GLITCH_W{1'b1}})) begin
         r_glitchCount <= r_glitchCount + GLITCH_ONE;
      end
   end

   // A push only happens when the current sample equals the candidate word,
   // so the registered bus sample is the word to store
   rx_word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_data     (r_data),
      .i_ready    (out_ready),
      .o_valid    (out_valid),
      .o_data     (out_data),
      .o_dropFlag (overflow)
   );

   assign keep_data    = r_keep;
   assign floating     = r_drive_n;
   assign glitch_count = r_glitchCount;

endmodule

// File: tb/tb_tristate_bus_receiver.sv
// Self-checking bench for tristate_bus_receiver: directed windows plus a
// randomized phase, checked every cycle against a window-level model.
module tb_tristate_bus_receiver;

   localparam int WIDTH = 8;
   localparam int SC    = 2;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bus_drive_n = 1'b1;
   logic [WIDTH-1:0] bus_data = '0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] keep_data;
   logic             floating;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             overflow;
   logic [7:0]       glitch_count;

   int total = 0;
   int bad   = 0;

   tristate_bus_receiver #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (SC),
      .DEPTH         (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus_drive_n  (bus_drive_n),
      .bus_data     (bus_data),
      .keep_data    (keep_data),
      .floating     (floating),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .glitch_count (glitch_count)
   );

   always #5 clk = ~clk;

   // Model state: the bus sample seen at the previous edge, the data history
   // of the current window, and the FIFO contents as a plain queue
   logic             mPrevDn = 1'b1;
   logic [WIDTH-1:0] mPrevData = '0;
   logic [WIDTH-1:0] mKeep = '0;
   bit               mInWin = 1'b0;
   bit               mCaptured = 1'b0;
   int               mHist[$];
   logic [WIDTH-1:0] mFifo[$];
   bit               mOverflow = 1'b0;
   int               mGlitch = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // A window captures its word once its last SC samples are all the same
   function automatic bit windowStable();
      int n;
      n = mHist.size();
      if (n < SC) return 1'b0;
      for (int i = 1; i < SC; i++) begin
         if (mHist[n-1-i] != mHist[n-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Reference model: each edge acts on the bus sample taken one edge earlier
   always @(posedge clk or posedge rst) begin
      bit               pop;
      bit               pushReq;
      logic [WIDTH-1:0] pushWord;
      if (rst) begin
         mPrevDn   = 1'b1;
         mPrevData = '0;
         mKeep     = '0;
         mInWin    = 1'b0;
         mCaptured = 1'b0;
         mHist.delete();
         mFifo.delete();
         mOverflow = 1'b0;
         mGlitch   = 0;
      end else begin
         pop      = (mFifo.size() > 0) && out_ready;
         pushReq  = 1'b0;
         pushWord = '0;
         if (mPrevDn == 1'b0) begin
            mKeep = mPrevData;
            if (!mInWin) begin
               mInWin    = 1'b1;
               mCaptured = 1'b0;
               mHist.delete();
            end
            mHist.push_back(int'(mPrevData));
            if (!mCaptured && windowStable()) begin
               pushReq   = 1'b1;
               pushWord  = mPrevData;
               mCaptured = 1'b1;
            end
         end else begin
            if (mInWin && !mCaptured && mGlitch < 255) mGlitch++;
            mInWin = 1'b0;
         end
         if (pushReq && mFifo.size() == DEPTH && !pop) mOverflow = 1'b1;
         if (pop) void'(mFifo.pop_front());
         if (pushReq && mFifo.size() < DEPTH) mFifo.push_back(pushWord);
         mPrevDn   = bus_drive_n;
         mPrevData = bus_data;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      checkOutput("keep_data", 32'(keep_data), 32'(mKeep));
      checkOutput("floating", 32'(floating), 32'(mPrevDn));
      checkOutput("out_valid", 32'(out_valid), 32'(mFifo.size() > 0));
      checkOutput("out_data", 32'(out_data), (mFifo.size() > 0) ? 32'(mFifo[0]) : 32'd0);
      checkOutput("overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("glitch_count", 32'(glitch_count), 32'(mGlitch));
   end

   // Drive the bus and consumer for n rising edges; returns 2 ns after the last
   task automatic applyStimulus(input logic dn, input logic [WIDTH-1:0] d, input logic rdy, input int n);
      bus_drive_n = dn;
      bus_data    = d;
      out_ready   = rdy;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic resetDut();
      rst         = 1'b1;
      bus_drive_n = 1'b1;
      bus_data    = '0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_floating", 32'(floating), 32'd1);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_keep", 32'(keep_data), 32'd0);
      rst = 1'b0;

      // Asynchronous reset mid-cycle with a word in the FIFO and a live window
      applyStimulus(1'b0, 8'h5A, 1'b0, 4);
      checkOutput("pre_async_valid", 32'(out_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_floating", 32'(floating), 32'd1);
      checkOutput("async_valid", 32'(out_valid), 32'd0);
      checkOutput("async_data", 32'(out_data), 32'd0);
      checkOutput("async_keep", 32'(keep_data), 32'd0);
      checkOutput("async_glitch", 32'(glitch_count), 32'd0);
      bus_drive_n = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      applyStimulus(1'b1, 8'h00, 1'b0, 2);
      checkOutput("post_async_valid", 32'(out_valid), 32'd0);

      // Nominal capture and its latency
      applyStimulus(1'b0, 8'hA5, 1'b0, 2);
      checkOutput("nom_not_yet", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 8'hA5, 1'b0, 1);
      checkOutput("nom_valid", 32'(out_valid), 32'd1);
      checkOutput("nom_data", 32'(out_data), 32'hA5);
      applyStimulus(1'b0, 8'hA5, 1'b0, 2);
      checkOutput("nom_keep", 32'(keep_data), 32'hA5);
      applyStimulus(1'b1, 8'h00, 1'b0, 2);
      checkOutput("nom_floating", 32'(floating), 32'd1);
      checkOutput("nom_keep_held", 32'(keep_data), 32'hA5);
      applyStimulus(1'b1, 8'h00, 1'b1, 1);
      checkOutput("nom_drained", 32'(out_valid), 32'd0);

      // Settling: a changing word restarts the debounce without a glitch
      applyStimulus(1'b0, 8'h11, 1'b0, 1);
      applyStimulus(1'b0, 8'h22, 1'b0, 4);
      applyStimulus(1'b1, 8'h00, 1'b0, 3);
      checkOutput("settle_data", 32'(out_data), 32'h22);
      checkOutput("settle_glitch", 32'(glitch_count), 32'd0);
      applyStimulus(1'b1, 8'h00, 1'b1, 1);
      checkOutput("settle_one_word", 32'(out_valid), 32'd0);

      // Glitch windows and counter saturation
      applyStimulus(1'b0, 8'h33, 1'b0, 1);
      applyStimulus(1'b1, 8'h00, 1'b0, 3);
      checkOutput("glitch_one", 32'(glitch_count), 32'd1);
      checkOutput("glitch_no_capture", 32'(out_valid), 32'd0);
      for (int i = 0; i < 299; i++) begin
         applyStimulus(1'b0, 8'h33, 1'b0, 1);
         applyStimulus(1'b1, 8'h00, 1'b0, 2);
      end
      checkOutput("glitch_saturated", 32'(glitch_count), 32'd255);

      // Overflow: five windows into a four-deep FIFO
      resetDut();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0, 3);
         applyStimulus(1'b1, 8'h00, 1'b0, 2);
      end
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         checkOutput("ovf_drain_valid", 32'(out_valid), 32'd1);
         checkOutput("ovf_drain_data", 32'(out_data), 32'(i));
         applyStimulus(1'b1, 8'h00, 1'b1, 1);
      end
      checkOutput("ovf_empty", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h00, 1'b0, 1);

      // Full FIFO with a pop on the push edge accepts the new word
      resetDut();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0, 3);
         applyStimulus(1'b1, 8'h00, 1'b0, 2);
      end
      applyStimulus(1'b0, 8'h06, 1'b0, 2);
      applyStimulus(1'b0, 8'h06, 1'b1, 1);
      applyStimulus(1'b1, 8'h00, 1'b0, 1);
      checkOutput("fullpop_overflow", 32'(overflow), 32'd0);
      checkOutput("fullpop_head", 32'(out_data), 32'd2);
      applyStimulus(1'b1, 8'h00, 1'b1, 3);
      checkOutput("fullpop_tail", 32'(out_data), 32'd6);
      applyStimulus(1'b1, 8'h00, 1'b1, 1);
      checkOutput("fullpop_empty", 32'(out_valid), 32'd0);

      // Randomized windows, restarts, glitches and consumer back-pressure
      resetDut();
      for (int s = 0; s < 500; s++) begin
         applyStimulus(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                       8'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       $urandom_range(1, 4));
      end
      applyStimulus(1'b1, 8'h00, 1'b1, 8);
      checkOutput("rand_drained", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tristate_bus_receiver.md
Name: tristate_bus_receiver

Overview:
- Reader end of the team's tri-state / switch-level bus. Drivers put a word on a shared bus and pull an active-low drive enable low, the same polarity as a PMOS pass gate.
- This block samples the bus, holds the last driven value as a bus keeper, and debounces each drive window.
- It captures exactly one stable word per window into a small FIFO, drained through a valid/ready interface.
- It sits between the switch-level bus models and the synchronous core logic.

Parameters:
- WIDTH, 8, bus data width in bits.
- STABLE_CYCLES, 2, consecutive identical driven samples needed before capture; legal range 1..15.
- DEPTH, 4, FIFO depth in words; must be a power of 2, at least 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_drive_n  input  1  active-low drive enable from the bus driver; 0 means the bus is driven.
- bus_data  input  WIDTH  shared bus data; valid only while bus_drive_n=0.
- keep_data  output  WIDTH  bus-keeper value: last driven sample.
- floating  output  1  high while the registered bus_drive_n is 1.
- out_valid  output  1  FIFO not empty.
- out_data  output  WIDTH  FIFO head word.
- out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
- overflow  output  1  sticky; set when a capture is dropped because the FIFO is full.
- glitch_count  output  8  saturating count of aborted drive windows.

Behaviour:
- Reset (async assert, sync use after release) drives these values: keep_data=0, floating=1, out_valid=0, out_data=0, overflow=0, glitch_count=0, FSM=IDLE, FIFO empty, sample registers r_drive_n=1 and r_data=0.
- Reset asserted mid-window or mid-FIFO discards everything. No partial word may appear after reset.
- Input stage: bus_drive_n and bus_data are registered every cycle into r_drive_n and r_data. The FSM acts only on the registered values.
- keep_data loads r_data on every cycle with r_drive_n=0 and holds otherwise. floating equals r_drive_n.
- FSM states:
  - IDLE: when r_drive_n=0, set prev=r_data and cnt=1. Go to HOLD and push if STABLE_CYCLES=1; otherwise go to SETTLE.
  - SETTLE:
    - r_drive_n=1: abort, glitch_count+1 (saturating at 255), go to IDLE.
    - r_data≠prev: set prev=r_data, cnt=1, stay in SETTLE. This is a restart, not a glitch.
    - r_data=prev: cnt+1. When cnt reaches STABLE_CYCLES, push prev and go to HOLD.
  - HOLD: ignore data changes. Go to IDLE when r_drive_n=1. Only one word is captured per window.
- Latency: call E0 the first edge that samples bus_drive_n=0. The push happens at edge E0+STABLE_CYCLES, and out_valid is high after that edge.
- FIFO: first-word-fall-through; out_data is the head word, and is 0 when empty.
  - Pop when out_valid and out_ready.
  - Push and pop in the same cycle are both performed, including when full: the pop frees the slot.
  - Push when full without a pop: the word is dropped, overflow is set and stays 1 until rst.
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- out_ready while empty has no effect.

Decomposition:
- Shared package (bus_rx_pkg):
  - state enum {IDLE, SETTLE, HOLD}, 2 bits.
  - GLITCH_W=8 constant.
  - ptr-width helper based on $clog2.
- One sub-module, rx_word_fifo (WIDTH, DEPTH), holds the storage, pointers, full/empty, and the push-when-full drop flag.
- The top level holds the input registers, keeper, FSM, and glitch counter.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle. All outputs take their reset values immediately, with floating=1 and out_valid=0.
- Nominal capture (STABLE_CYCLES=2, out_ready=0): hold bus_drive_n=0 with bus_data=0xA5 for 5 cycles. out_valid=1 after E0+2, out_data=0xA5, keep_data=0xA5. After release, floating=1 and keep_data stays 0xA5.
- Settling: drive 0x11 for 1 cycle, then 0x22 for 4 cycles. Exactly one word, 0x22, is captured and glitch_count=0.
- Glitch: drive 0x33 for 1 cycle, then release. No capture and glitch_count=1. Repeat 300 times; glitch_count saturates at 255.
- Overflow (DEPTH=4, out_ready=0): run 5 windows with data 1..5. The FIFO holds 1,2,3,4, overflow=1, and 5 is dropped. Then drain with out_ready=1: out_data reads 1,2,3,4 and out_valid falls.
- Full plus simultaneous pop: with the FIFO full and out_ready=1 on the push edge, word 6 is accepted and overflow stays 0 after a fresh reset.
